// File: rtl/alu_modport_if.sv
// Operand/opcode bundle into the ALU and its registered result (err only with ALU_ERR_EN).
// master drives operands and opcodes; slave returns C (and err).
interface alu_modport_if;
    logic signed [4:0] A;
    logic signed [4:0] B;
    logic              ALU_en;
    logic              a_en;
    logic [2:0]        a_op;
    logic              b_en;
    logic [1:0]        b_op;
    logic signed [5:0] C;
`ifdef ALU_ERR_EN
    logic              err;
`endif

    modport master (
        output A, B, ALU_en, a_en, a_op, b_en, b_op,
`ifdef ALU_ERR_EN
        input  err,
`endif
        input  C
    );

    modport slave (
        input  A, B, ALU_en, a_en, a_op, b_en, b_op,
`ifdef ALU_ERR_EN
        output err,
`endif
        output C
    );
endinterface

// File: rtl/alu_modport.sv
// Two-set 6-bit signed ALU with held result; ALU_ERR_EN adds a registered illegal-opcode flag.
// Latency 1 cycle (C registered); no backpressure, inputs are sampled every edge.
module alu_modport (
    input  logic         clk,
    input  logic         rst_n,
    alu_modport_if.slave bus
);
    logic signed [5:0] a_sx;
    logic signed [5:0] b_sx;
    logic signed [5:0] res;
    logic              upd;

    assign a_sx = {bus.A[4], bus.A};
    assign b_sx = {bus.B[4], bus.B};

    // upd=0 means C holds: disabled, no set selected, or illegal opcode.
    always_comb begin
        res = '0;
        upd = 1'b0;
        if (bus.ALU_en) begin
            unique case ({bus.a_en, bus.b_en})
                2'b10: begin
                    upd = 1'b1;
                    case (bus.a_op)
                        3'd0:    res = a_sx + b_sx;
                        3'd1:    res = a_sx - b_sx;
                        3'd2:    res = a_sx ^ b_sx;
                        3'd3:    res = a_sx & b_sx;
                        3'd4:    res = a_sx & b_sx;
                        3'd5:    res = a_sx | b_sx;
                        3'd6:    res = ~(a_sx ^ b_sx);
                        default: upd = 1'b0;
                    endcase
                end
                2'b01: begin
                    upd = 1'b1;
                    case (bus.b_op)
                        2'd0:    res = ~(a_sx & b_sx);
                        2'd1:    res = a_sx + b_sx;
                        2'd2:    res = a_sx + b_sx;
                        default: upd = 1'b0;
                    endcase
                end
                2'b11: begin
                    upd = 1'b1;
                    case (bus.b_op)
                        2'd0:    res = a_sx ^ b_sx;
                        2'd1:    res = ~(a_sx ^ b_sx);
                        2'd2:    res = a_sx - 6'sd1;
                        default: res = b_sx + 6'sd2;
                    endcase
                end
                default: upd = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.C <= '0;
        end else if (upd) begin
            bus.C <= res;
        end
    end

`ifdef ALU_ERR_EN
    logic illegal;

    assign illegal = bus.ALU_en &&
                     (( bus.a_en && !bus.b_en && (bus.a_op == 3'd7)) ||
                      (!bus.a_en &&  bus.b_en && (bus.b_op == 2'd3)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err <= 1'b0;
        end else begin
            bus.err <= illegal;
        end
    end
`endif
endmodule

// File: tb/tb_alu_modport.sv
// Directed and random bench for alu_modport against an integer reference model.
module tb_alu_modport;
    logic clk;
    logic rst_n;
    alu_modport_if bus ();

    alu_modport dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int exp_c  = 0;
    int exp_err = 0;

    function automatic int wrap6(int v);
        int m;
        m = v & 63;
        return (m >= 32) ? m - 64 : m;
    endfunction

    // Returns 1 when the operation produces a new C, with the unwrapped value in r.
    function automatic bit model(int a, int b, bit en, bit ae, int aop, bit be, int bop,
                                 output int r);
        r = 0;
        if (!en || (!ae && !be)) return 1'b0;
        if (ae && !be) begin
            case (aop)
                0: r = a + b;
                1: r = a - b;
                2: r = a ^ b;
                3, 4: r = a & b;
                5: r = a | b;
                6: r = ~(a ^ b);
                default: return 1'b0;
            endcase
        end else if (!ae && be) begin
            case (bop)
                0: r = ~(a & b);
                1, 2: r = a + b;
                default: return 1'b0;
            endcase
        end else begin
            case (bop)
                0: r = a ^ b;
                1: r = ~(a ^ b);
                2: r = a - 1;
                default: r = b + 2;
            endcase
        end
        return 1'b1;
    endfunction

    task automatic chk(string tag, int got, int exp);
        checks++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(string tag, int a, int b, bit en, bit ae, int aop, bit be, int bop);
        int r;
        bit legal;
        logic [4:0] a5;
        logic [4:0] b5;
        a5 = a[4:0];
        b5 = b[4:0];
        bus.A = a5;
        bus.B = b5;
        bus.ALU_en = en;
        bus.a_en = ae;
        bus.a_op = aop[2:0];
        bus.b_en = be;
        bus.b_op = bop[1:0];
        legal = model(a, b, en, ae, aop, be, bop, r);
        if (legal) exp_c = wrap6(r);
        exp_err = (en && ((ae && !be && aop == 7) || (!ae && be && bop == 3))) ? 1 : 0;
        @(posedge clk);
        #1;
        chk(tag, int'(bus.C), exp_c);
`ifdef ALU_ERR_EN
        chk({tag, "_err"}, int'(bus.err), exp_err);
`endif
    endtask

    initial begin
        bus.A = '0; bus.B = '0; bus.ALU_en = 1'b0; bus.a_en = 1'b0;
        bus.a_op = '0; bus.b_en = 1'b0; bus.b_op = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk("reset_async", int'(bus.C), 0);
`ifdef ALU_ERR_EN
        chk("reset_err", int'(bus.err), 0);
`endif
        @(posedge clk); #1;
        chk("reset_hold", int'(bus.C), 0);
        #2 rst_n = 1'b1;
        exp_c = 0;

        step("add_7_5",       7,   5, 1, 1, 0, 0, 0);
        step("add_neg",     -15, -15, 1, 1, 0, 0, 0);
        step("nand_3_5",      3,   5, 1, 0, 0, 1, 0);
        step("b_illegal",     3,   5, 1, 0, 0, 1, 3);
        step("both_b_plus2",  0,  15, 1, 1, 5, 1, 3);
        step("both_a_minus1",-15,  0, 1, 1, 2, 1, 2);
        step("add_12",        7,   5, 1, 1, 0, 0, 0);
        step("hold_dis",     -9,  11, 0, 1, 1, 0, 0);
        step("hold_dis2",     4,  -3, 0, 0, 0, 1, 1);
        step("hold_noset",   13,   2, 1, 0, 6, 0, 2);
        step("a_illegal",     1,   1, 1, 1, 7, 0, 0);
        step("sub_wrap",    -15,  15, 1, 1, 1, 0, 0);
        step("xnor",          6,  -7, 1, 1, 6, 0, 0);
        step("and4",         -5,  13, 1, 1, 4, 0, 0);
        step("or",           -8,   3, 1, 1, 5, 0, 0);

        // Reset pulled between edges while an operation is in flight.
        #2 rst_n = 1'b0;
        #1 chk("mid_reset_async", int'(bus.C), 0);
        bus.ALU_en = 1'b1; bus.a_en = 1'b1; bus.b_en = 1'b0; bus.a_op = 3'd0;
        @(posedge clk); #1;
        chk("mid_reset_hold1", int'(bus.C), 0);
        @(posedge clk); #1;
        chk("mid_reset_hold2", int'(bus.C), 0);
        #3 rst_n = 1'b1;
        exp_c = 0;
        step("post_reset", 10, 4, 1, 1, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            int a;
            int b;
            a = int'($urandom_range(30)) - 15;
            b = int'($urandom_range(30)) - 15;
            step("rand", a, b, ($urandom_range(7) != 0), $urandom_range(1) == 1,
                 int'($urandom_range(7)), $urandom_range(1) == 1, int'($urandom_range(3)));
            checks++;
            assert (bus.C !== -6'sd32)
            else begin
                fails++;
                $error("FAIL rand_not_m32: observed %0d expected not -32", bus.C);
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/alu_modport.md
ALU_MODPORT -- requirements
Module: alu_modport

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port A, input, 5, signed operand; legal range -15..15, -16 never driven.
REQ-004 SHALL have port B, input, 5, signed operand; legal range -15..15, -16 never driven.
REQ-005 SHALL have port ALU_en, input, 1, global enable; 0 means C holds.
REQ-006 SHALL have port a_en, input, 1, selects the A-operation set.
REQ-007 SHALL have port a_op, input, 3, A-set opcode.
REQ-008 SHALL have port b_en, input, 1, selects the B-operation set.
REQ-009 SHALL have port b_op, input, 2, B-set opcode.
REQ-010 SHALL have port C, output, 6, signed registered result.
REQ-011 SHALL have port err, output, 1, illegal-opcode flag; present only when ALU_ERR_EN is defined.

Function
REQ-012 SHALL sign-extend A and B to 6 bits before every operation; all results SHALL be 6-bit two's complement, wrapping on overflow.
REQ-013 SHALL register C on the rising clk edge; a result SHALL appear on C one cycle after the inputs are sampled.
REQ-014 SHALL hold C when ALU_en=0.
REQ-015 SHALL hold C when ALU_en=1, a_en=0 and b_en=0.
REQ-016 With ALU_en=1, a_en=1, b_en=0, SHALL select by a_op: 0 A+B; 1 A-B; 2 A XOR B; 3 A AND B; 4 A AND B; 5 A OR B; 6 A XNOR B; 7 illegal, hold C.
REQ-017 With ALU_en=1, a_en=0, b_en=1, SHALL select by b_op: 0 A NAND B; 1 A+B; 2 A+B; 3 illegal, hold C.
REQ-018 With ALU_en=1, a_en=1, b_en=1, SHALL select by b_op: 0 A XOR B; 1 A XNOR B; 2 A-1; 3 B+2; a_op is ignored.
REQ-019 Bitwise operations SHALL act on the 6-bit sign-extended operands.
REQ-020 C SHALL never be X/Z after reset, and SHALL never equal -32 for legal operand ranges.

Reset
REQ-021 rst_n=0 SHALL clear C to 0 immediately, independent of clk.
REQ-022 C SHALL remain 0 on every clock edge while rst_n=0, including when reset asserts mid-operation.
REQ-023 After rst_n deasserts, the first result SHALL appear on C one cycle after the first sampling edge.
REQ-024 When ALU_ERR_EN is defined, rst_n=0 SHALL also clear err to 0.

Configuration
REQ-025 ALU_ERR_EN defined: err SHALL be registered alongside C.
- err=1 for one cycle after sampling ALU_en=1 with either a_en=1, b_en=0, a_op=7, or a_en=0, b_en=1, b_op=3.
- err=0 otherwise.
REQ-026 ALU_ERR_EN undefined: the err port and its logic SHALL be absent; C behaviour SHALL be identical in both builds.

Verification
REQ-027 ALU_en=1, a_en=1, b_en=0, a_op=0, A=7, B=5 -> C=12 next cycle; with A=-15, B=-15 -> C=-30.
REQ-028 a_en=0, b_en=1, b_op=0, A=3, B=5 -> C=-2; then b_op=3 -> C stays -2, err=1 when the macro is defined.
REQ-029 a_en=1, b_en=1, b_op=3, B=15 -> C=17; b_op=2, A=-15 -> C=-16.
REQ-030 C=12, then ALU_en=0, or ALU_en=1 with a_en=b_en=0, while inputs change -> C stays 12 for all cycles.
REQ-031 a_op=7 with a_en=1, b_en=0 -> C unchanged; then a_op=1, A=-15, B=15 -> C=-30.
REQ-032 rst_n pulled low between clock edges mid-stream -> C=0 at once and held; release -> normal results resume one cycle later.
